// File: rtl/s_div_seq_unit.sv
// Sequential radix-2 restoring divider for the divide-capable streaming PE.
// Accepts DIV/REM/ABSDIV/ABSREM over the PE operand handshake and returns the
// quotient/remainder pair with a valid that respects the global PEA stall.

package pea_pkg;
  localparam int N_BITS = 32;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    MUL    = 4'd3,
    DIV    = 4'd4,
    REM    = 4'd5,
    ABSDIV = 4'd6,
    ABSREM = 4'd7
  } fu_instr_t;
endpackage

module s_div_seq_unit
  import pea_pkg::*;
#(
  parameter int DATA_W = N_BITS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mage_done_i,
  input  logic              pea_ready_i,
  input  fu_instr_t         instr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              ops_valid_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] res_o,
  output logic [DATA_W-1:0] rem_q_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_reg;
  fu_instr_t         op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] bmag_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              div0_reg;
  logic              ovf_reg;
  logic              valid_reg;
  logic [DATA_W-1:0] res_reg;
  logic [DATA_W-1:0] remq_reg;

  logic              is_abs;
  logic              is_rem;
  logic              accept_op;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              b_zero;
  logic              ovf_c;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  assign ready_o = (state_reg == S_IDLE);
  assign valid_o = valid_reg;
  assign res_o   = res_reg;
  assign rem_q_o = remq_reg;

  // Operand magnitudes, one restoring shift-subtract step, and the final sign fix-up
  always_comb begin
    is_abs    = (op_reg == ABSDIV) || (op_reg == ABSREM);
    is_rem    = (op_reg == REM) || (op_reg == ABSREM);
    accept_op = ops_valid_i && ((instr_i == DIV) || (instr_i == REM) ||
                                (instr_i == ABSDIV) || (instr_i == ABSREM));

    // |MIN| wraps to the MIN bit pattern, which is 2^(DATA_W-1) read as unsigned
    a_mag  = a_reg[DATA_W-1] ? (~a_reg + 1'b1) : a_reg;
    b_mag  = b_reg[DATA_W-1] ? (~b_reg + 1'b1) : b_reg;
    b_zero = (b_reg == '0);
    ovf_c  = !is_abs && (a_reg == MIN_VAL) && (b_reg == '1);

    // Dividend bits are shifted out of the quotient register MSB first
    shifted = {rem_reg, quo_reg[DATA_W-1]};
    diff    = shifted - {1'b0, bmag_reg};
    if (!diff[DATA_W]) begin
      rem_step = diff[DATA_W-1:0];
      quo_step = {quo_reg[DATA_W-2:0], 1'b1};
    end else begin
      rem_step = shifted[DATA_W-1:0];
      quo_step = {quo_reg[DATA_W-2:0], 1'b0};
    end

    if (div0_reg) begin
      q_fix = '1;
      r_fix = is_abs ? a_mag : a_reg;
    end else if (ovf_reg) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end else if (is_abs) begin
      q_fix = quo_reg;
      r_fix = rem_reg;
    end else begin
      q_fix = (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]) ? (~quo_reg + 1'b1) : quo_reg;
      r_fix = a_reg[DATA_W-1] ? (~rem_reg + 1'b1) : rem_reg;
    end
  end

  // Control FSM and datapath registers; abort beats stall, stall freezes everything
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= S_IDLE;
      op_reg    <= NOP;
      a_reg     <= '0;
      b_reg     <= '0;
      bmag_reg  <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      div0_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
      res_reg   <= '0;
      remq_reg  <= '0;
    end else if (mage_done_i) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      res_reg   <= '0;
      remq_reg  <= '0;
    end else if (pea_ready_i) begin
      case (state_reg)
        S_IDLE: begin
          if (accept_op) begin
            op_reg    <= instr_i;
            a_reg     <= a_i;
            b_reg     <= b_i;
            state_reg <= S_PREP;
          end
        end
        S_PREP: begin
          quo_reg   <= a_mag;
          rem_reg   <= '0;
          bmag_reg  <= b_mag;
          div0_reg  <= b_zero;
          ovf_reg   <= ovf_c;
          cnt_reg   <= CNT_W'(DATA_W);
          state_reg <= (b_zero || ovf_c) ? S_FIX : S_CALC;
        end
        S_CALC: begin
          quo_reg <= quo_step;
          rem_reg <= rem_step;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          res_reg   <= is_rem ? r_fix : q_fix;
          remq_reg  <= is_rem ? q_fix : r_fix;
          valid_reg <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          valid_reg <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_div_seq_unit.sv
// Directed bench for s_div_seq_unit with hand-computed results (DATA_W = 32).

module tb_s_div_seq_unit;
  import pea_pkg::*;

  logic        clk_i;
  logic        rst_n_i;
  logic        mage_done_i;
  logic        pea_ready_i;
  fu_instr_t   instr_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ops_valid_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] res_o;
  logic [31:0] rem_q_o;

  int n_checks = 0;
  int n_errors = 0;

  s_div_seq_unit #(.DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mage_done_i (mage_done_i),
    .pea_ready_i (pea_ready_i),
    .instr_i     (instr_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .ops_valid_i (ops_valid_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .res_o       (res_o),
    .rem_q_o     (rem_q_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one operation, scrambles the inputs after accept, and counts edges to valid
  task automatic start_op(input string tag, input fu_instr_t op,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    instr_i     = op;
    a_i         = a;
    b_i         = b;
    ops_valid_i = 1'b1;
    check({tag, "/ready_idle"}, 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    ops_valid_i = 1'b0;
    instr_i     = ADD;
    a_i         = $urandom;
    b_i         = $urandom;
    check({tag, "/ready_busy"}, 32'(ready_o), 32'd0);
  endtask

  task automatic wait_valid(inout int lat);
    while (!valid_o && lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input fu_instr_t op,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic [31:0] exp_rq);
    int lat;
    start_op(tag, op, a, b);
    lat = 0;
    wait_valid(lat);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/res"}, res_o, exp_res);
    check({tag, "/rem_q"}, rem_q_o, exp_rq);
    $display("op %-10s a=%08h b=%08h res=%08h rem_q=%08h lat=%0d", tag, a, b, res_o, rem_q_o, lat);
    @(posedge clk_i); #1;
    check({tag, "/valid_consumed"}, 32'(valid_o), 32'd0);
    check({tag, "/ready_after"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n_i     = 1'b0;
    mage_done_i = 1'b0;
    pea_ready_i = 1'b1;
    instr_i     = NOP;
    a_i         = '0;
    b_i         = '0;
    ops_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset/ready", 32'(ready_o), 32'd1);
    check("reset/valid", 32'(valid_o), 32'd0);
    check("reset/res", res_o, 32'd0);
    check("reset/rem_q", rem_q_o, 32'd0);
    rst_n_i = 1'b1;

    run_op("div_pos",    DIV,    32'd100,  32'd7,  34, 32'd14,       32'd2);
    run_op("div_neg",    DIV,    -32'd100, 32'd7,  34, -32'd14,      -32'd2);
    run_op("rem_neg",    REM,    -32'd100, 32'd7,  34, -32'd2,       -32'd14);
    run_op("absdiv",     ABSDIV, -32'd100, -32'd7, 34, 32'd14,       32'd2);
    run_op("absrem",     ABSREM, -32'd100, -32'd7, 34, 32'd2,        32'd14);
    run_op("div_small",  DIV,    32'd7,    -32'd100, 34, 32'd0,      32'd7);
    run_op("div_min3",   DIV,    32'h80000000, 32'd3, 34, 32'hD5555556, 32'hFFFFFFFE);
    run_op("div_m1m1",   DIV,    32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'd1, 32'd0);
    run_op("div_by0",    DIV,    32'd5,    32'd0,  2,  32'hFFFFFFFF, 32'd5);
    run_op("absdiv_by0", ABSDIV, -32'd5,   32'd0,  2,  32'hFFFFFFFF, 32'd5);
    run_op("rem_by0",    REM,    -32'd5,   32'd0,  2,  -32'd5,       32'hFFFFFFFF);
    run_op("div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 2, 32'h80000000, 32'd0);
    run_op("absdiv_min", ABSDIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'd0);

    // Non-divide instruction must not be accepted
    @(negedge clk_i);
    instr_i     = MUL;
    a_i         = 32'd6;
    b_i         = 32'd3;
    ops_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("nondiv/ready", 32'(ready_o), 32'd1);
      check("nondiv/valid", 32'(valid_o), 32'd0);
    end
    ops_valid_i = 1'b0;
    $display("op nondiv     instr=MUL not accepted");

    // Stall 5 cycles mid-CALC and 5 cycles in DONE
    start_op("stall", DIV, 32'd100, 32'd7);
    lat = 0;
    repeat (5) begin @(posedge clk_i); #1; lat++; end
    pea_ready_i = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; lat++; end
    check("stall/valid_frozen", 32'(valid_o), 32'd0);
    pea_ready_i = 1'b1;
    wait_valid(lat);
    check("stall/latency", 32'(lat), 32'd39);
    pea_ready_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("stall/valid_held", 32'(valid_o), 32'd1);
    check("stall/res_held", res_o, 32'd14);
    check("stall/rem_q_held", rem_q_o, 32'd2);
    pea_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("stall/consumed", 32'(valid_o), 32'd0);
    $display("op stall      a=100 b=7 res=%08h lat=%0d", res_o, lat);

    // Kernel-done abort mid-CALC clears the outputs
    start_op("abort", DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk_i);
    #1;
    mage_done_i = 1'b1;
    @(posedge clk_i); #1;
    mage_done_i = 1'b0;
    check("abort/ready", 32'(ready_o), 32'd1);
    check("abort/valid", 32'(valid_o), 32'd0);
    check("abort/res", res_o, 32'd0);
    check("abort/rem_q", rem_q_o, 32'd0);
    $display("op abort      mage_done mid-CALC");
    run_op("div_9_3", DIV, 32'd9, 32'd3, 34, 32'd3, 32'd0);

    // Asynchronous reset mid-operation
    start_op("rst_mid", DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("rst_mid/ready", 32'(ready_o), 32'd1);
    check("rst_mid/res", res_o, 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    $display("op rst_mid    reset during CALC");
    run_op("div_after", DIV, 32'd100, 32'd7, 34, 32'd14, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
